// File: rtl/udp_cmd_fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// udp_cmd_fifo_arb_pkg
// Shared definitions for the UDP command FIFO arbiter:
//   - state_t        : arbiter FSM state encoding
//   - LAST_BIT       : index of the last-word flag inside a command word
//   - DEF_DATA_WIDTH : default command word width (flag + 32-bit payload)
// -----------------------------------------------------------------------------
package udp_cmd_fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int LAST_BIT       = 32;
    localparam int DEF_DATA_WIDTH = 33;

endpackage

// File: rtl/udp_rr_pick.sv
// -----------------------------------------------------------------------------
// udp_rr_pick
// Purely combinational round-robin picker. Priority starts at i_last+1 and
// wraps modulo NUM_REQ; the first requesting index in that order wins.
// Ports:
//   i_req  [NUM_REQ-1:0] : request vector
//   i_last [IDX_W-1:0]   : index of the previous owner
//   i_en                 : pick enable; o_win is all zero when low
//   o_win  [NUM_REQ-1:0] : one-hot winner (all zero if no request)
// -----------------------------------------------------------------------------
module udp_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_win
);

    logic w_found;

    // Two ascending passes: indices above the last owner first, then the
    // wrapped-around indices up to and including the last owner.
    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        if (i_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && i_req[i] && (i > int'(i_last))) begin
                    o_win[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && i_req[i] && (i <= int'(i_last))) begin
                    o_win[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/udp_cmd_fifo_arb.sv
// -----------------------------------------------------------------------------
// udp_cmd_fifo_arb
// Arbitrates NUM_REQ command requesters onto one command FIFO write port.
// A requester owns the port for a whole command (words until the last-word
// flag), then the grant rotates round-robin. A stalled-by-idle owner loses
// the grant after TIMEOUT consecutive idle cycles and err_timeout is raised.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_data  : per-requester word valid / word (slice i = req i)
//   req_ready           : per-requester word accepted
//   fifo_wr_data/_en    : command FIFO write port
//   fifo_wr_full        : FIFO full, stalls the current burst
//   fifo_almost_full    : FIFO almost full, blocks new grants only
//   grant               : one-hot current owner, zero when idle
//   cmd_cnt             : completed command count (wraps)
//   err_timeout/err_clr : sticky timeout flag and its clear
// -----------------------------------------------------------------------------
module udp_cmd_fifo_arb
    import udp_cmd_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_wr_full,
    input  logic                          fifo_almost_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic [15:0]                   cmd_cnt,
    output logic                          err_timeout,
    input  logic                          err_clr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_last_owner;
    logic [15:0]          r_cmd_cnt;
    logic                 r_err;
    logic [CNT_W-1:0]     r_to_cnt;

    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]     w_last_nxt;
    logic [15:0]          w_cmd_cnt_nxt;
    logic [CNT_W-1:0]     w_to_cnt_nxt;
    logic                 w_to_evt;

    logic [NUM_REQ-1:0]   w_win;
    logic                 w_pick_en;
    logic [IDX_W-1:0]     w_owner_idx;
    logic                 w_owner_valid;
    logic                 w_burst;
    logic                 w_xfer;

    assign w_burst   = (r_state == ST_BURST);
    assign w_pick_en = (r_state == ST_IDLE) && !fifo_almost_full;

    udp_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_last (r_last_owner),
        .i_en   (w_pick_en),
        .o_win  (w_win)
    );

    // Owner-side mux driven from the registered grant; with no grant every
    // term stays zero, so IDLE outputs are quiet without extra gating.
    always_comb begin
        fifo_wr_data  = '0;
        w_owner_valid = 1'b0;
        w_owner_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                fifo_wr_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_owner_valid = req_valid[i];
                w_owner_idx   = IDX_W'(i);
            end
        end
    end

    assign req_ready  = w_burst ? (r_grant & {NUM_REQ{~fifo_wr_full}}) : '0;
    assign fifo_wr_en = w_burst && w_owner_valid && !fifo_wr_full;
    assign w_xfer     = fifo_wr_en;

    assign grant       = r_grant;
    assign cmd_cnt     = r_cmd_cnt;
    assign err_timeout = r_err;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last_owner;
        w_cmd_cnt_nxt = r_cmd_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_to_evt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_to_cnt_nxt = '0;
                if (|w_win) begin
                    w_grant_nxt = w_win;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_xfer) begin
                    w_to_cnt_nxt = '0;
                    if (fifo_wr_data[LAST_BIT]) begin
                        w_state_nxt   = ST_IDLE;
                        w_grant_nxt   = '0;
                        w_last_nxt    = w_owner_idx;
                        w_cmd_cnt_nxt = r_cmd_cnt + 16'd1;
                    end
                end else if (fifo_wr_full) begin
                    // A full FIFO is not the owner's fault: restart idle count.
                    w_to_cnt_nxt = '0;
                end else if (r_to_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th consecutive idle cycle.
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_last_nxt   = w_owner_idx;
                    w_to_cnt_nxt = '0;
                    w_to_evt     = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_cmd_cnt    <= '0;
            r_err        <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_owner <= w_last_nxt;
            r_cmd_cnt    <= w_cmd_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            // Set has priority over a simultaneous clear.
            r_err        <= w_to_evt | (r_err & ~err_clr);
        end
    end

endmodule
